// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: multi-cycle mult/div into HI/LO,
// mthi/mtlo writes and a combinational mfhi/mflo read port.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDURD
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } mdu_op_e;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    mdu_op_e     op;
    logic [31:0] temp_hi, temp_lo;
    logic [3:0]  cnt;
    logic        div_zero;
    logic        accept;

    logic signed [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;

    assign op     = mdu_op_e'(MDUOp);
    assign busy   = (cnt != 4'd0);
    assign accept = start && !busy &&
                    (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU);

    // Signed divide runs on magnitudes so 0x80000000 / -1 and B == 0 stay well defined.
    always_comb begin
        prod_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u  = {32'd0, A} * {32'd0, B};
        a_neg   = (op == OP_DIV) && A[31];
        b_neg   = (op == OP_DIV) && B[31];
        a_mag   = a_neg ? (32'd0 - A) : A;
        b_mag   = b_neg ? (32'd0 - B) : B;
        divisor = (B == 32'd0) ? 32'd1 : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem     = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            HI       <= '0;
            LO       <= '0;
            temp_hi  <= '0;
            temp_lo  <= '0;
            cnt      <= '0;
            div_zero <= 1'b0;
        end else begin
            if (accept) begin
                case (op)
                    OP_MULT: begin
                        {temp_hi, temp_lo} <= $unsigned(prod_s);
                        cnt      <= MULT_CNT;
                        div_zero <= 1'b0;
                    end
                    OP_MULTU: begin
                        {temp_hi, temp_lo} <= prod_u;
                        cnt      <= MULT_CNT;
                        div_zero <= 1'b0;
                    end
                    default: begin
                        temp_hi  <= rem;
                        temp_lo  <= quot;
                        cnt      <= DIV_CNT;
                        div_zero <= (B == 32'd0);
                    end
                endcase
            end else if (cnt == 4'd1) begin
                if (!div_zero) begin
                    HI <= temp_hi;
                    LO <= temp_lo;
                end
                cnt <= '0;
            end else if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (!busy && op == OP_MTHI) HI <= A;
            if (!busy && op == OP_MTLO) LO <= A;
        end
    end

    always_comb begin
        case (op)
            OP_MFHI: MDURD = HI;
            OP_MFLO: MDURD = LO;
            default: MDURD = '0;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: table of operations plus hand-written
// sequences for busy collisions, mid-operation reset and HI/LO reads.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  MDUOp;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO, MDURD;

    int checks = 0;
    int errors = 0;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .MDURD(MDURD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        int          cycles;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        start = 1'b0;
        MDUOp = 4'd0;
        A     = '0;
        B     = '0;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_hilo(input logic [31:0] hi, input logic [31:0] lo);
        start = 1'b0;
        MDUOp = 4'd5;
        A     = hi;
        step();
        MDUOp = 4'd6;
        A     = lo;
        step();
        idle();
    endtask

    // Counts samples with busy high; bounded so a stuck busy cannot hang the run.
    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        int m;

        vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'h00000003, 32'h0, 32'h0, 5,  32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1] = '{4'd2, 32'hFFFFFFFE, 32'h00000003, 32'h0, 32'h0, 5,  32'h00000002, 32'hFFFFFFFA};
        vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 32'h0, 32'h0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{4'd4, 32'h00000007, 32'h00000002, 32'h0, 32'h0, 10, 32'h00000001, 32'h00000003};
        vecs[4] = '{4'd4, 32'h00000005, 32'h00000000, 32'h1234, 32'h5678, 10, 32'h00001234, 32'h00005678};
        vecs[5] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h1, 32'h1, 10, 32'h00000000, 32'h80000000};
        vecs[6] = '{4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0, 5,  32'h3FFFFFFF, 32'h00000001};
        vecs[7] = '{4'd3, 32'h00000007, 32'hFFFFFFFE, 32'h0, 32'h0, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[8] = '{4'd3, 32'hFFFFFFFF, 32'h00000000, 32'hAAAA, 32'hBBBB, 10, 32'h0000AAAA, 32'h0000BBBB};
        vecs[9] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 5,  32'hFFFFFFFE, 32'h00000001};

        reset = 1'b1;
        idle();
        step();
        step();
        check32("reset_busy", 32'(busy), 32'd0);
        check32("reset_hi", HI, 32'd0);
        check32("reset_lo", LO, 32'd0);
        check32("reset_mdurd", MDURD, 32'd0);
        reset = 1'b0;
        step();

        // start with a non-arithmetic op must not occupy the unit
        start = 1'b1;
        MDUOp = 4'd7;
        step();
        idle();
        check32("start_op7_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 10; i++) begin
            write_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
            start = 1'b1;
            MDUOp = vecs[i].op;
            A     = vecs[i].a;
            B     = vecs[i].b;
            check32($sformatf("vec%0d_busy_at_start", i), 32'(busy), 32'd0);
            step();
            idle();
            wait_done(n);
            check32($sformatf("vec%0d_busy_cycles", i), 32'(n), 32'(vecs[i].cycles));
            check32($sformatf("vec%0d_hi", i), HI, vecs[i].exp_hi);
            check32($sformatf("vec%0d_lo", i), LO, vecs[i].exp_lo);
        end

        // start and mthi while a mult is in flight are both ignored
        write_hilo(32'h0, 32'h0);
        start = 1'b1;
        MDUOp = 4'd1;
        A     = 32'd5;
        B     = 32'd6;
        step();
        n = busy ? 1 : 0;
        start = 1'b1;
        MDUOp = 4'd3;
        A     = 32'd100;
        B     = 32'd7;
        step();
        if (busy) n++;
        start = 1'b0;
        MDUOp = 4'd5;
        A     = 32'hDEAD;
        step();
        idle();
        wait_done(m);
        check32("collide_busy_cycles", 32'(n + m), 32'd5);
        check32("collide_hi", HI, 32'd0);
        check32("collide_lo", LO, 32'd30);
        step();
        step();
        check32("collide_no_div", 32'(busy), 32'd0);

        // reset during a mult aborts it with no later commit
        write_hilo(32'h11, 32'h22);
        start = 1'b1;
        MDUOp = 4'd1;
        A     = 32'd4;
        B     = 32'd5;
        step();
        idle();
        step();
        step();
        reset = 1'b1;
        step();
        check32("abort_busy", 32'(busy), 32'd0);
        check32("abort_hi", HI, 32'd0);
        check32("abort_lo", LO, 32'd0);
        reset = 1'b0;
        repeat (6) step();
        check32("abort_no_commit_lo", LO, 32'd0);
        check32("abort_no_commit_busy", 32'(busy), 32'd0);

        // mthi/mtlo followed by mfhi/mflo reads
        write_hilo(32'h13579BDF, 32'hCAFEBABE);
        MDUOp = 4'd8;
        #1;
        check32("mflo", MDURD, 32'hCAFEBABE);
        MDUOp = 4'd7;
        #1;
        check32("mfhi", MDURD, 32'h13579BDF);
        MDUOp = 4'd0;
        #1;
        check32("mdurd_none", MDURD, 32'd0);
        MDUOp = 4'd12;
        #1;
        check32("mdurd_op12", MDURD, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
